// File: rtl/junction_pkg.sv
// junction_pkg: lamp codes, phase states and lane helpers shared by the junction controller
package junction_pkg;
  localparam logic [1:0] COL_OFF = 2'b00;
  localparam logic [1:0] COL_RED = 2'b01;
  localparam logic [1:0] COL_AMBER = 2'b10;
  localparam logic [1:0] COL_GREEN = 2'b11;
  localparam int NUM_LANES = 3;
  localparam logic [1:0] NO_LANE = 2'd3;
  typedef enum logic [1:0] {ALL_RED, ARB, GREEN, AMBER} phase_t;
  function automatic logic [1:0] next_lane(logic [1:0] l);
    return l >= 2'(NUM_LANES - 1) ? 2'd0 : l + 2'd1;
  endfunction
  function automatic logic [5:0] lamp_colours(phase_t s, logic [1:0] l);
    lamp_colours = {3{COL_RED}};
    for (int i = 0; i < NUM_LANES; i++)
      if (l == 2'(i)) lamp_colours[2*i+:2] = s == GREEN ? COL_GREEN : s == AMBER ? COL_AMBER : COL_RED;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clock_50 into a one-cycle tick every TICK_DIV enabled cycles
//   clock_50/reset_n: clock and async active-low reset; enable: count only when high
//   clear: restart the count at 0; tick: high on the last count of each period
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock_50,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] count;
  assign tick = enable && count == W'(TICK_DIV - 1);
  always_ff @(posedge clock_50 or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/junction_phase_controller.sv
// junction_phase_controller: round-robin green/amber/all-red sequencing for a 3-lane junction
//   clock_50/reset_n: clock and async active-low reset; enable: freeze everything when low
//   lane_req: per-lane vehicle request; force_all_red: drive to and hold all-red
//   lane_colour: 2-bit lamp code per lane; active_lane: green/amber lane or 3
//   phase_start: pulse on GREEN entry; secs_remaining: ticks left in the timed phase
module junction_phase_controller
  import junction_pkg::*;
#(
  parameter int TICK_DIV     = 50000000,
  parameter int GREEN_TICKS  = 10,
  parameter int AMBER_TICKS  = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int TMR_W        = 8
) (
  input  logic             clock_50,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [2:0]       lane_req,
  input  logic             force_all_red,
  output logic [5:0]       lane_colour,
  output logic [1:0]       active_lane,
  output logic             phase_start,
  output logic [TMR_W-1:0] secs_remaining
);
  phase_t state, state_n;
  logic [1:0] lane, lane_n, last, last_n, c1, c2, pick;
  logic [TMR_W-1:0] timer, timer_n;
  logic tick, expire, others;
  // restarting the prescaler on every state change makes each phase exactly N ticks long
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock_50(clock_50),
    .reset_n(reset_n),
    .enable(enable),
    .clear(enable && state_n != state),
    .tick(tick)
  );
  assign expire = tick && timer == TMR_W'(1);
  assign others = |(lane_req & ~(3'b001 << lane));
  assign c1 = next_lane(last);
  assign c2 = next_lane(c1);
  assign pick = lane_req[c1] ? c1 : lane_req[c2] ? c2 : lane_req[last] ? last : NO_LANE;
  assign active_lane = lane;
  assign secs_remaining = timer;
  always_comb begin
    state_n = state;
    lane_n = lane;
    last_n = last;
    timer_n = tick ? timer - 1'b1 : timer;
    if (enable)
      case (state)
        ALL_RED: if (expire) begin
          state_n = force_all_red ? ALL_RED : ARB;
          timer_n = force_all_red ? TMR_W'(ALLRED_TICKS) : '0;
        end
        ARB: begin
          timer_n = '0;
          if (pick != NO_LANE && !force_all_red) begin
            state_n = GREEN;
            lane_n = pick;
            last_n = pick;
            timer_n = TMR_W'(GREEN_TICKS);
          end
        end
        GREEN: if (force_all_red || (expire && others)) begin
          state_n = AMBER;
          timer_n = TMR_W'(AMBER_TICKS);
        end else if (expire) timer_n = TMR_W'(GREEN_TICKS);
        AMBER: if (expire) begin
          state_n = ALL_RED;
          lane_n = NO_LANE;
          timer_n = TMR_W'(ALLRED_TICKS);
        end
        default: begin
          state_n = ALL_RED;
          lane_n = NO_LANE;
          timer_n = TMR_W'(ALLRED_TICKS);
        end
      endcase
  end
  // lamp outputs come from the next-state values so they are clean flop outputs
  always_ff @(posedge clock_50 or negedge reset_n)
    if (!reset_n) begin
      state <= ALL_RED;
      lane <= NO_LANE;
      last <= 2'd2;
      timer <= TMR_W'(ALLRED_TICKS);
      lane_colour <= {3{COL_RED}};
      phase_start <= 1'b0;
    end else begin
      state <= state_n;
      lane <= lane_n;
      last <= last_n;
      timer <= timer_n;
      lane_colour <= lamp_colours(state_n, lane_n);
      phase_start <= state_n == GREEN && state != GREEN;
    end
endmodule

// File: tb/tb_junction_phase_controller.sv
// tb_junction_phase_controller: directed plan plus random traffic against a cycle-count reference model
module tb_junction_phase_controller;
  localparam int TD = 4, GT = 3, AT = 2, AR = 1;
  localparam int P_RED = 0, P_ARB = 1, P_GRN = 2, P_AMB = 3;
  logic clk = 0, reset_n = 0, enable = 1, force_all_red = 0;
  logic [2:0] lane_req = 3'b001;
  logic [5:0] lane_colour;
  logic [1:0] active_lane;
  logic phase_start;
  logic [7:0] secs_remaining;
  int compared = 0, mismatched = 0;
  int m_ph = P_RED, m_lane = 3, m_last = 2, m_cyc = 0, m_len = AR;
  bit m_ps = 0;
  int n, pulses;

  always #5 clk = ~clk;

  junction_phase_controller #(
    .TICK_DIV(TD), .GREEN_TICKS(GT), .AMBER_TICKS(AT), .ALLRED_TICKS(AR), .TMR_W(8)
  ) dut (
    .clock_50(clk), .reset_n(reset_n), .enable(enable), .lane_req(lane_req),
    .force_all_red(force_all_red), .lane_colour(lane_colour), .active_lane(active_lane),
    .phase_start(phase_start), .secs_remaining(secs_remaining)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: a phase of N ticks is N*TD enabled cycles; it expires on its last one
  task automatic step();
    bit ex, f, oth;
    int c, ch;
    ex = (m_ph != P_ARB) && (m_cyc == m_len * TD - 1);
    f = 0;
    ch = 3;
    oth = 0;
    for (int i = 0; i < 3; i++) if (i != m_lane && lane_req[i]) oth = 1;
    case (m_ph)
      P_RED: if (ex) begin m_cyc = 0; if (!force_all_red) m_ph = P_ARB; end else m_cyc++;
      P_ARB: begin
        for (int k = 1; k <= 3; k++) begin
          c = (m_last + k) % 3;
          if (!f && lane_req[c]) begin f = 1; ch = c; end
        end
        if (f && !force_all_red) begin
          m_ph = P_GRN; m_lane = ch; m_last = ch; m_cyc = 0; m_len = GT; m_ps = 1;
        end
      end
      P_GRN: if (force_all_red) begin m_ph = P_AMB; m_cyc = 0; m_len = AT; end
        else if (ex) begin m_cyc = 0; if (oth) begin m_ph = P_AMB; m_len = AT; end end
        else m_cyc++;
      default: if (ex) begin m_ph = P_RED; m_lane = 3; m_len = AR; m_cyc = 0; end else m_cyc++;
    endcase
  endtask

  function automatic logic [5:0] exp_colour();
    logic [5:0] v;
    for (int i = 0; i < 3; i++)
      v[2*i+:2] = m_lane != i ? 2'd1 : m_ph == P_GRN ? 2'd3 : m_ph == P_AMB ? 2'd2 : 2'd1;
    return v;
  endfunction

  initial begin : model
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_ph = P_RED; m_lane = 3; m_last = 2; m_cyc = 0; m_len = AR; m_ps = 0;
      end else begin
        m_ps = 0;
        if (enable) step();
      end
      #1;
      chk("colour", 32'(lane_colour), 32'(exp_colour()));
      chk("active_lane", 32'(active_lane), m_lane);
      chk("phase_start", 32'(phase_start), 32'(m_ps));
      chk("secs", 32'(secs_remaining), m_ph == P_ARB ? 0 : m_len - m_cyc / TD);
    end
  end

  task automatic wait_ps(input int lim, output int cnt);
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (phase_start !== 1'b1 && cnt < lim);
    chk("phase_start_seen", 32'(phase_start), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1;
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk); #1;
      if (e <= 3) begin chk("t1_allred_secs", 32'(secs_remaining), 1); chk("t1_allred_col", 32'(lane_colour), 6'b010101); end
      if (e == 4) begin chk("t1_arb_lane", 32'(active_lane), 3); chk("t1_arb_secs", 32'(secs_remaining), 0); end
      if (e == 5) begin
        chk("t1_green_col", 32'(lane_colour), 6'b010111); chk("t1_ps", 32'(phase_start), 1);
        chk("t1_green_secs", 32'(secs_remaining), 3); chk("t1_green_lane", 32'(active_lane), 0);
      end
      if (e == 6) chk("t1_ps_single", 32'(phase_start), 0);
      if (e == 16) chk("t1_last_secs", 32'(secs_remaining), 1);
      if (e == 17) begin
        chk("t1_rearm_secs", 32'(secs_remaining), 3); chk("t1_rearm_ps", 32'(phase_start), 0);
        chk("t1_rearm_col", 32'(lane_colour), 6'b010111);
      end
    end
    @(negedge clk); lane_req = 3'b111;
    wait_ps(60, n); chk("t2_lane_a", 32'(active_lane), 1); chk("t2_gap_a", n, 25);
    wait_ps(60, n); chk("t2_lane_b", 32'(active_lane), 2); chk("t2_gap_b", n, 25);
    wait_ps(60, n); chk("t2_lane_c", 32'(active_lane), 0); chk("t2_gap_c", n, 25);
    wait_ps(60, n); chk("t2_lane_d", 32'(active_lane), 1); chk("t2_gap_d", n, 25);
    @(negedge clk); lane_req = 3'b001;
    wait_ps(60, n); chk("t3_lane0", 32'(active_lane), 0);
    n = 0;
    while (lane_colour[1:0] == 2'b11 && n < 50) begin
      n++;
      @(negedge clk); if (n == 5) lane_req = 3'b101;
      @(posedge clk); #1;
    end
    chk("t3_green_len", n, 12);
    chk("t3_amber", 32'(lane_colour[1:0]), 2);
    wait_ps(30, n); chk("t3_lane2", 32'(active_lane), 2); chk("t3_gap", n, 13);
    @(negedge clk); lane_req = 3'b111;
    repeat (2) @(negedge clk);
    force_all_red = 1;
    @(posedge clk); #1;
    chk("t4_force_amber", 32'(lane_colour[5:4]), 2); chk("t4_force_secs", 32'(secs_remaining), AT);
    n = 0;
    while (lane_colour[5:4] == 2'b10 && n < 40) begin n++; @(posedge clk); #1; end
    chk("t4_amber_len", n, 8);
    chk("t4_allred_lane", 32'(active_lane), 3);
    pulses = 0;
    repeat (20) begin @(posedge clk); #1; if (phase_start) pulses++; end
    chk("t4_held_pulses", pulses, 0);
    chk("t4_held_col", 32'(lane_colour), 6'b010101);
    @(negedge clk); force_all_red = 0;
    wait_ps(10, n); chk("t4_resume_lane", 32'(active_lane), 0);
    n = 0;
    while (lane_colour[1:0] != 2'b10 && n < 40) begin @(posedge clk); #1; n++; end
    chk("t5_amber_seen", 32'(lane_colour[1:0]), 2);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); enable = !(i >= 2 && i < 12);
      @(posedge clk); #1;
      if (lane_colour[1:0] != 2'b10) break;
      n++;
    end
    enable = 1;
    chk("t5_amber_len", n, 18);
    wait_ps(40, n); chk("t6_pre_lane", 32'(active_lane), 1);
    @(posedge clk); #3; reset_n = 0; #1;
    chk("t6_async_col", 32'(lane_colour), 6'b010101);
    chk("t6_async_lane", 32'(active_lane), 3);
    chk("t6_async_secs", 32'(secs_remaining), AR);
    repeat (2) @(negedge clk);
    reset_n = 1;
    wait_ps(20, n); chk("t6_post_lane", 32'(active_lane), 0); chk("t6_post_gap", n, 5);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) lane_req = 3'($urandom);
      if ($urandom_range(0, 63) == 0) force_all_red = ~force_all_red;
      enable = $urandom_range(0, 9) != 0;
    end
    @(negedge clk); force_all_red = 0; enable = 1;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
